// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle logic/shift/compare ops plus a WIDTH-step
// shift-add unsigned multiplier returning either half of the 2*WIDTH product.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SRL   = 4'd4;
  localparam logic [3:0] OP_SRA   = 4'd5;
  localparam logic [3:0] OP_SLL   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_SLTU  = 4'd8;
  localparam logic [3:0] OP_MULLO = 4'd9;
  localparam logic [3:0] OP_MULHU = 4'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE.

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     c_q, c_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic                 mulhi_q, mulhi_d;

  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     alu_res;
  logic [2*WIDTH-1:0]   acc_sum;

  assign shamt = B[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUOp)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(A) >>> shamt);
      OP_SLL:  alu_res = A << shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: alu_res = '0;
    endcase
  end

  assign acc_sum = acc_q + (mplr_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mulhi_d = mulhi_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (ALUOp == OP_MULLO || ALUOp == OP_MULHU) begin
            mcand_d = {{WIDTH{1'b0}}, A};
            mplr_d  = B;
            acc_d   = '0;
            cnt_d   = '0;
            mulhi_d = (ALUOp == OP_MULHU);
            state_d = MUL;
          end else begin
            c_d     = alu_res;
            state_d = DONE;
          end
        end
      end
      MUL: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        // Last partial product goes straight into C so DONE follows the final step.
        if (cnt_q == SHW'(WIDTH-1)) begin
          c_d     = mulhi_q ? acc_sum[2*WIDTH-1:WIDTH] : acc_sum[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      c_q     <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mulhi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mulhi_q <= mulhi_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign C         = c_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=32): directed ops with literal expectations, plus a
// per-cycle scoreboard driven by an arithmetic model of the op table and latencies.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic [3:0]  ALUOp;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] C;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUOp(ALUOp), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time exceeded, bench never finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic [63:0] p;
    int sh;
    p  = {32'h0, a} * {32'h0, b};
    sh = int'(b % 32);
    case (op)
      4'd0:    model = a + b;
      4'd1:    model = a - b;
      4'd2:    model = a & b;
      4'd3:    model = a | b;
      4'd4:    model = a >> sh;
      4'd5:    model = 32'($signed(a) >>> sh);
      4'd6:    model = a << sh;
      4'd7:    model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:    model = (a < b) ? 32'd1 : 32'd0;
      4'd9:    model = p[31:0];
      4'd10:   model = p[63:32];
      default: model = 32'd0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          due_q[$];
  bit          head_seen = 0;
  bit          prev_valid = 0, prev_ready = 0;
  logic [31:0] prev_c = '0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      due_q.delete();
      head_seen  = 0;
      prev_valid = 0;
    end else begin
      check("in_ready_vs_model", {31'b0, in_ready}, {31'b0, (exp_q.size() == 0)});
      check("busy_vs_model", {31'b0, busy}, {31'b0, (exp_q.size() != 0)});
      if (out_valid && prev_valid && !prev_ready)
        check("c_stable_under_stall", C, prev_c);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          if (!head_seen) begin
            check("latency_cycle", cyc, due_q[0]);
            head_seen = 1;
          end
          if (out_ready) begin
            check("c_vs_model", C, exp_q[0]);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            head_seen = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, ALUOp));
        due_q.push_back(cyc + ((ALUOp == 4'd9 || ALUOp == 4'd10) ? 33 : 1));
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_c     = C;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    A = a; B = b; ALUOp = op; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALUOp = 4'($urandom_range(0, 15));
  endtask

  task automatic take(input string name, input logic [31:0] exp, input int stall);
    int n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    if (!out_valid) check({name, "_timeout"}, 32'd0, 32'd1);
    check(name, C, exp);
    repeat (stall) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic op(input string name, input logic [31:0] a, input logic [31:0] b,
                    input logic [3:0] o, input logic [31:0] exp);
    send(a, b, o);
    take(name, exp, 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUOp = '0;
    repeat (3) step();
    reset = 1'b0;
    check("reset_c", C, 32'd0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);

    op("add_wrap", 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0);
    op("sub_wrap", 32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF);
    op("and", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd2, 32'h00F0_00F0);
    op("or", 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd3, 32'hFFF0_FFF0);
    op("sra", 32'h8000_0000, 32'h24, 4'd5, 32'hF800_0000);
    op("srl", 32'h8000_0000, 32'h24, 4'd4, 32'h0800_0000);
    op("sll_31", 32'd1, 32'd31, 4'd6, 32'h8000_0000);
    op("sll_w_plus_1", 32'd1, 32'd33, 4'd6, 32'd2);
    op("slt", 32'hFFFF_FFFF, 32'd1, 4'd7, 32'd1);
    op("sltu", 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd0);
    op("op12_zero", 32'd5, 32'd6, 4'd12, 32'd0);
    op("op15_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd15, 32'd0);
    op("mullo_2p16", 32'h0001_0000, 32'h0001_0000, 4'd9, 32'd0);
    op("mulhu_2p16", 32'h0001_0000, 32'h0001_0000, 4'd10, 32'd1);
    op("mullo_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 32'd1);
    op("mulhu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 32'hFFFF_FFFE);
    op("mullo_small", 32'd3, 32'd5, 4'd9, 32'd15);
    op("mulhu_shift", 32'h8000_0000, 32'd4, 4'd10, 32'd2);

    // Backpressure: result held 10 cycles while a new op waits on in_valid.
    send(32'd10, 32'd3, 4'd1);
    while (!out_valid && cyc < 100_000) step();
    A = 32'd7; B = 32'd8; ALUOp = 4'd0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("stall_c", C, 32'd7);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_in_ready", {31'b0, in_ready}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("after_drain_in_ready", {31'b0, in_ready}, 32'd1);
    check("after_drain_out_valid", {31'b0, out_valid}, 32'd0);
    check("after_drain_c_held", C, 32'd7);
    step();
    in_valid = 1'b0;
    take("queued_add", 32'd15, 0);

    // Reset partway through a multiply discards it.
    send(32'h1234_5678, 32'h9ABC_DEF0, 4'd9);
    repeat (14) step();
    check("mid_mul_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_mul_reset_c", C, 32'd0);
    check("mid_mul_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_mul_reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_mul_reset_busy", {31'b0, busy}, 32'd0);
    repeat (40) begin
      if (out_valid) check("discarded_mul_out_valid", 32'd1, 32'd0);
      step();
    end
    op("add_after_reset", 32'd2, 32'd3, 4'd0, 32'd5);

    // A few model-only ops with varied operands.
    op("mix_sra", 32'h8F00_0001, 32'd7, 4'd5, 32'hFF1E_0000);
    op("mix_slt_neg", 32'h8000_0000, 32'h7FFF_FFFF, 4'd7, 32'd1);
    op("mix_mulhu", 32'h0001_0001, 32'h0001_0000, 4'd10, 32'd1);

    repeat (3) step();
    if (exp_q.size() != 0) check("leftover_expected", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
